// File: rtl/nonce_header_builder_if.sv
// Header-field, control and message-handshake bundle for nonce_header_builder.
// msg_valid/msg_ready: a message transfers on a rising edge where both are high; while
// msg_valid is high and msg_ready is low, message and nonce_out hold their values.
interface nonce_header_builder_if;
  logic          start;
  logic          abort;
  logic [31:0]   version;
  logic [255:0]  prev_hash;
  logic [255:0]  merkle_root;
  logic [31:0]   time_stamp;
  logic [31:0]   bits;
  logic [31:0]   nonce_start;
  logic [31:0]   nonce_end;
  logic [1023:0] message;
  logic          msg_valid;
  logic          msg_ready;
  logic [31:0]   nonce_out;
  logic          busy;
  logic          done;

  modport master (
    output start, abort, version, prev_hash, merkle_root, time_stamp, bits,
           nonce_start, nonce_end, msg_ready,
    input  message, msg_valid, nonce_out, busy, done
  );

  modport slave (
    input  start, abort, version, prev_hash, merkle_root, time_stamp, bits,
           nonce_start, nonce_end, msg_ready,
    output message, msg_valid, nonce_out, busy, done
  );
endinterface

// File: rtl/nonce_header_builder.sv
// Latches a block header, walks the nonce range and emits one padded 1024-bit message per nonce.
// Optional macro BYTE_SWAP_EN: place header fields in little-endian wire byte order.
module nonce_header_builder #(
  parameter logic [31:0] NONCE_STEP   = 32'd1,
  parameter int unsigned MSG_LEN_BITS = 640
) (
  input  logic                   clk,
  input  logic                   rst,
  nonce_header_builder_if.slave  bus,
  output logic [2:0]             o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_PRESENT = 3'd2,
    S_ADVANCE = 3'd3,
    S_FINISH  = 3'd4
  } state_t;

  localparam logic [63:0] LEN_FIELD = 64'(MSG_LEN_BITS);

  state_t         r_state;
  state_t         w_state_next;

  logic [31:0]    r_version;
  logic [255:0]   r_prev_hash;
  logic [255:0]   r_merkle_root;
  logic [31:0]    r_time_stamp;
  logic [31:0]    r_bits;
  logic [31:0]    r_nonce_end;
  logic [31:0]    r_nonce;

  logic [1023:0]  r_message;
  logic           r_msg_valid;
  logic [31:0]    r_nonce_out;

  logic           w_accept;
  logic           w_last;
  logic [1023:0]  w_message;

`ifdef BYTE_SWAP_EN
  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [255:0] bswap256(input logic [255:0] x);
    logic [255:0] y;
    for (int i = 0; i < 32; i++) begin
      y[8*i +: 8] = x[8*(31-i) +: 8];
    end
    return y;
  endfunction

  assign w_message = {bswap32(r_version), bswap256(r_prev_hash), bswap256(r_merkle_root),
                      bswap32(r_time_stamp), bswap32(r_bits), bswap32(r_nonce),
                      1'b1, 319'b0, LEN_FIELD};
`else
  assign w_message = {r_version, r_prev_hash, r_merkle_root, r_time_stamp, r_bits, r_nonce,
                      1'b1, 319'b0, LEN_FIELD};
`endif

  assign w_accept = r_msg_valid && bus.msg_ready;
  // Remaining distance to the end, modulo 2^32, makes wrapped ranges work unchanged.
  assign w_last   = (r_nonce_end - r_nonce) < NONCE_STEP;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        w_state_next = bus.abort ? S_FINISH : S_PRESENT;
      end
      S_PRESENT: begin
        if (bus.abort) begin
          w_state_next = S_FINISH;
        end else if (w_accept) begin
          w_state_next = w_last ? S_FINISH : S_ADVANCE;
        end
      end
      S_ADVANCE: begin
        w_state_next = bus.abort ? S_FINISH : S_LOAD;
      end
      S_FINISH: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_version     <= '0;
      r_prev_hash   <= '0;
      r_merkle_root <= '0;
      r_time_stamp  <= '0;
      r_bits        <= '0;
      r_nonce_end   <= '0;
      r_nonce       <= '0;
      r_message     <= '0;
      r_msg_valid   <= 1'b0;
      r_nonce_out   <= '0;
    end else begin
      if (r_state == S_IDLE && bus.start) begin
        r_version     <= bus.version;
        r_prev_hash   <= bus.prev_hash;
        r_merkle_root <= bus.merkle_root;
        r_time_stamp  <= bus.time_stamp;
        r_bits        <= bus.bits;
        r_nonce_end   <= bus.nonce_end;
        r_nonce       <= bus.nonce_start;
      end
      if (r_state == S_ADVANCE) begin
        r_nonce <= r_nonce + NONCE_STEP;
      end
      if (r_state == S_LOAD && w_state_next == S_PRESENT) begin
        r_message   <= w_message;
        r_nonce_out <= r_nonce;
      end
      // Valid tracks PRESENT exactly, so an abort or accept drops it on the following edge.
      r_msg_valid <= (w_state_next == S_PRESENT);
    end
  end

  assign bus.message   = r_message;
  assign bus.msg_valid = r_msg_valid;
  assign bus.nonce_out = r_nonce_out;
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.done      = (r_state == S_FINISH);
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_nonce_header_builder.sv
// Bench for nonce_header_builder: hand-written corner sequences, a vector table and random
// ranges, all checked against a nonce-list and message-layout model.
module tb_nonce_header_builder;

  localparam int MAX_CYC = 2000;

  typedef struct {
    logic [31:0]  version;
    logic [255:0] prev_hash;
    logic [255:0] merkle_root;
    logic [31:0]  time_stamp;
    logic [31:0]  bits;
  } hdr_t;

  typedef struct {
    logic [31:0] ns;
    logic [31:0] ne;
    int          rdy_pct;
    int          abort_idx;
    bit          abort_acc;
    bit          use4;
    int          exp_cnt;
  } vec_t;

  // clock / reset
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          start, abort, msg_ready;
  logic [31:0]   version, time_stamp, bits, nonce_start, nonce_end;
  logic [255:0]  prev_hash, merkle_root;
  logic          use4;
  logic [2:0]    dbg1, dbg4, dbg_idle;
  logic [1023:0] s_message;
  logic [31:0]   s_nonce_out;
  logic          s_valid, s_busy, s_done;

  int total;
  int bad;
  logic [31:0] exp_q[$];

  nonce_header_builder_if bus1();
  nonce_header_builder_if bus4();

  assign bus1.start = start;             assign bus4.start = start;
  assign bus1.abort = abort;             assign bus4.abort = abort;
  assign bus1.version = version;         assign bus4.version = version;
  assign bus1.prev_hash = prev_hash;     assign bus4.prev_hash = prev_hash;
  assign bus1.merkle_root = merkle_root; assign bus4.merkle_root = merkle_root;
  assign bus1.time_stamp = time_stamp;   assign bus4.time_stamp = time_stamp;
  assign bus1.bits = bits;               assign bus4.bits = bits;
  assign bus1.nonce_start = nonce_start; assign bus4.nonce_start = nonce_start;
  assign bus1.nonce_end = nonce_end;     assign bus4.nonce_end = nonce_end;
  assign bus1.msg_ready = msg_ready;     assign bus4.msg_ready = msg_ready;

  nonce_header_builder #(.NONCE_STEP(32'd1)) dut (
    .clk(clk), .rst(rst), .bus(bus1.slave), .o_dbg_state(dbg1)
  );

  nonce_header_builder #(.NONCE_STEP(32'd4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave), .o_dbg_state(dbg4)
  );

  always_comb begin
    if (use4) begin
      s_message = bus4.message; s_nonce_out = bus4.nonce_out;
      s_valid = bus4.msg_valid; s_busy = bus4.busy; s_done = bus4.done;
    end else begin
      s_message = bus1.message; s_nonce_out = bus1.nonce_out;
      s_valid = bus1.msg_valid; s_busy = bus1.busy; s_done = bus1.done;
    end
  end

  // reference model
  function automatic logic [31:0] f32(input logic [31:0] x);
`ifdef BYTE_SWAP_EN
    logic [7:0] b[4];
    for (int i = 0; i < 4; i++) b[i] = x[8*i +: 8];
    return {b[0], b[1], b[2], b[3]};
`else
    return x;
`endif
  endfunction

  function automatic logic [255:0] f256(input logic [255:0] x);
    logic [255:0] r;
    r = x;
`ifdef BYTE_SWAP_EN
    for (int i = 0; i < 32; i++) r[8*(31-i) +: 8] = x[8*i +: 8];
`endif
    return r;
  endfunction

  function automatic logic [1023:0] model_msg(input hdr_t h, input logic [31:0] n);
    logic [1023:0] m;
    m = '0;
    m[1023:992] = f32(h.version);
    m[991:736]  = f256(h.prev_hash);
    m[735:480]  = f256(h.merkle_root);
    m[479:448]  = f32(h.time_stamp);
    m[447:416]  = f32(h.bits);
    m[415:384]  = f32(n);
    m[383]      = 1'b1;
    m[63:0]     = 64'd640;
    return m;
  endfunction

  task automatic model_nonces(input logic [31:0] ns, input logic [31:0] ne,
                              input logic [31:0] step, input int limit);
    logic [31:0] span;
    longint cnt;
    exp_q.delete();
    span = ne - ns;
    cnt = longint'(span / step) + 1;
    if (limit >= 0 && cnt > longint'(limit)) cnt = longint'(limit);
    for (longint k = 0; k < cnt; k++) exp_q.push_back(ns + 32'(k) * step);
  endtask

  // scoreboard helpers
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_msg(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    int widx;
    total++;
    if (act !== exp) begin
      bad++;
      widx = 0;
      for (int w = 31; w >= 0; w--) begin
        if (act[32*w +: 32] !== exp[32*w +: 32]) begin
          widx = w;
          break;
        end
      end
      $display("FAIL %s: word %0d got %h expected %h", name, widx,
               act[32*widx +: 32], exp[32*widx +: 32]);
    end
  endtask

  // driver tasks
  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic hdr_t get_hdr();
    hdr_t h;
    h.version = version; h.prev_hash = prev_hash; h.merkle_root = merkle_root;
    h.time_stamp = time_stamp; h.bits = bits;
    return h;
  endfunction

  task automatic randomize_hdr();
    version = $urandom; prev_hash = rand256(); merkle_root = rand256();
    time_stamp = $urandom; bits = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; msg_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (s_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, ok, 1);
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] got_q[$];
    hdr_t h;
    int cyc, ndone, abort_cyc, done_cyc, lim;
    bit aborted, any_done;
    do_reset();
    use4 = v.use4;
    randomize_hdr();
    nonce_start = v.ns;
    nonce_end = v.ne;
    h = get_hdr();
    lim = -1;
    if (v.abort_idx >= 0) lim = v.abort_idx + (v.abort_acc ? 1 : 0);
    model_nonces(v.ns, v.ne, v.use4 ? 32'd4 : 32'd1, lim);
    pulse_start();
    cyc = 0; ndone = 0; abort_cyc = -1; done_cyc = -1; aborted = 1'b0;
    while (ndone == 0 && cyc < MAX_CYC) begin
      abort = 1'b0;
      msg_ready = ($urandom_range(0, 99) < v.rdy_pct);
      @(negedge clk);
      if (s_valid && !aborted && v.abort_idx >= 0 && got_q.size() == v.abort_idx) begin
        abort = 1'b1;
        msg_ready = v.abort_acc;
        aborted = 1'b1;
        abort_cyc = cyc;
      end
      if (s_valid && msg_ready) begin
        if (got_q.size() < exp_q.size()) begin
          chk("nonce_out", s_nonce_out, exp_q[got_q.size()]);
          chk_msg("message", s_message, model_msg(h, exp_q[got_q.size()]));
        end
        got_q.push_back(s_nonce_out);
      end
      if (s_done) begin
        ndone++;
        done_cyc = cyc;
        chk("busy_at_done", s_busy, 1);
      end
      @(posedge clk);
      #1 cyc++;
    end
    abort = 1'b0;
    msg_ready = 1'b0;
    chk("done_seen", ndone, 1);
    chk("msg_count", got_q.size(), exp_q.size());
    if (v.exp_cnt >= 0) chk("tbl_count", got_q.size(), v.exp_cnt);
    if (aborted) chk("abort_done_lat", done_cyc - abort_cyc, 1);
    @(negedge clk);
    chk("idle_after_done", {s_busy, s_done, s_valid}, 0);
    any_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      any_done |= s_done;
    end
    chk("done_once", any_done, 0);
  endtask

  vec_t vecs[9];
  vec_t rv;
  hdr_t h;
  logic [1023:0] exp_m, snap_m;
  logic [31:0] snap_n, exp_ver, exp_nw;
  bit any;

  initial begin
    vecs[0] = '{32'd5,        32'd7,   100, -1, 1'b0, 1'b0, 3};
    vecs[1] = '{32'hFFFFFFFE, 32'd1,   100, -1, 1'b0, 1'b0, 4};
    vecs[2] = '{32'd0,        32'd10,  100, -1, 1'b0, 1'b1, 3};
    vecs[3] = '{32'd0,        32'd10,  100,  1, 1'b0, 1'b1, 1};
    vecs[4] = '{32'd9,        32'd9,    40, -1, 1'b0, 1'b0, 1};
    vecs[5] = '{32'd100,      32'd120,  60, -1, 1'b0, 1'b0, 21};
    vecs[6] = '{32'hFFFFFFFC, 32'd5,   100, -1, 1'b0, 1'b1, 3};
    vecs[7] = '{32'd10,       32'd20,  100,  2, 1'b1, 1'b0, 3};
    vecs[8] = '{32'd3,        32'd3,   100,  0, 1'b0, 1'b1, 0};

    total = 0; bad = 0; use4 = 1'b0;
    version = '0; prev_hash = '0; merkle_root = '0; time_stamp = '0; bits = '0;
    nonce_start = '0; nonce_end = '0;
    do_reset();

    // reset state
    @(negedge clk);
    chk("rst_flags", {s_valid, s_busy, s_done}, 0);
    chk("rst_nonce_out", s_nonce_out, 0);
    chk_msg("rst_message", s_message, '0);
    chk("rst_state_both", dbg1 == dbg4, 1);
    dbg_idle = dbg1;

    // zero header: latency and exact padding layout
    do_reset();
    nonce_start = 32'h12345678; nonce_end = 32'h12345678;
    pulse_start();
    @(negedge clk);
    chk("load_busy", s_busy, 1);
    chk("load_valid", s_valid, 0);
    chk("load_state_moved", dbg1 != dbg_idle, 1);
    @(negedge clk);
    chk("present_valid", s_valid, 1);
    exp_m = '0;
`ifdef BYTE_SWAP_EN
    exp_m[415:384] = 32'h78563412;
`else
    exp_m[415:384] = 32'h12345678;
`endif
    exp_m[383] = 1'b1;
    exp_m[63:0] = 64'h280;
    chk_msg("zero_header", s_message, exp_m);
    chk("zero_nonce_out", s_nonce_out, 32'h12345678);
    msg_ready = 1'b1;
    @(negedge clk);
    msg_ready = 1'b0;
    chk("single_done", {s_done, s_valid}, 2'b10);
    @(negedge clk);
    chk("single_idle", {s_busy, s_done}, 0);

    // version / nonce word placement
    do_reset();
    version = 32'h00000002;
    nonce_start = 32'h01020304; nonce_end = 32'h01020304;
    pulse_start();
    wait_valid("ver_wait");
`ifdef BYTE_SWAP_EN
    exp_ver = 32'h02000000; exp_nw = 32'h04030201;
`else
    exp_ver = 32'h00000002; exp_nw = 32'h01020304;
`endif
    chk("ver_word", s_message[1023:992], exp_ver);
    chk("nonce_word", s_message[415:384], exp_nw);
    chk("ver_nonce_out", s_nonce_out, 32'h01020304);

    // back-pressure: hold for 10 cycles, accept on the 11th
    do_reset();
    randomize_hdr();
    h = get_hdr();
    nonce_start = 32'd20; nonce_end = 32'd21;
    pulse_start();
    wait_valid("stall_wait");
    snap_m = s_message;
    snap_n = s_nonce_out;
    chk_msg("stall_first_msg", snap_m, model_msg(h, 32'd20));
    chk("stall_first_nonce", snap_n, 32'd20);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_hold", {s_valid, s_message == snap_m, s_nonce_out == snap_n}, 3'b111);
    end
    msg_ready = 1'b1;
    @(negedge clk);
    msg_ready = 1'b0;
    chk("stall_advance", {s_valid, s_busy}, 2'b01);
    repeat (2) @(negedge clk);
    chk("stall_next_valid", s_valid, 1);
    chk("stall_next_nonce", s_nonce_out, 32'd21);
    chk_msg("stall_next_msg", s_message, model_msg(h, 32'd21));

    // start while busy is ignored
    do_reset();
    randomize_hdr();
    h = get_hdr();
    nonce_start = 32'd0; nonce_end = 32'd1;
    pulse_start();
    wait_valid("busy_start_wait");
    version = ~version; prev_hash = ~prev_hash; nonce_start = 32'd100; nonce_end = 32'd100;
    pulse_start();
    @(negedge clk);
    chk("busy_start_nonce0", s_nonce_out, 32'd0);
    chk_msg("busy_start_msg0", s_message, model_msg(h, 32'd0));
    msg_ready = 1'b1;
    @(negedge clk);
    msg_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("busy_start_nonce1", {s_valid, s_nonce_out}, {1'b1, 32'd1});
    chk_msg("busy_start_msg1", s_message, model_msg(h, 32'd1));

    // reset mid-run: outputs cleared, no done pulse
    do_reset();
    randomize_hdr();
    nonce_start = 32'd0; nonce_end = 32'd50;
    msg_ready = 1'b1;
    pulse_start();
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    msg_ready = 1'b0;
    @(negedge clk);
    chk("midrst_flags", {s_valid, s_busy, s_done}, 0);
    chk("midrst_nonce_out", s_nonce_out, 0);
    chk_msg("midrst_message", s_message, '0);
    any = 1'b0;
    repeat (5) begin
      @(negedge clk);
      any |= (s_done | s_busy);
    end
    chk("midrst_quiet", any, 0);

    // vector table
    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // randomized ranges
    for (int i = 0; i < 8; i++) begin
      rv.ns = $urandom;
      if ($urandom_range(0, 1) == 1) rv.ns = 32'hFFFFFFFF - 32'($urandom_range(0, 6));
      rv.ne = rv.ns + 32'($urandom_range(0, 12));
      rv.use4 = ($urandom_range(0, 1) == 1);
      rv.rdy_pct = int'($urandom_range(30, 100));
      rv.abort_acc = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 2) == 0) rv.abort_idx = int'($urandom_range(0, 2));
      else rv.abort_idx = -1;
      rv.exp_cnt = -1;
      run_vec(rv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
